// File: rtl/motor_mixer_if.sv
// Bundle of PID-side request signals and ESC-side motor outputs for the mixer.
interface motor_mixer_if #(
  parameter int unsigned BIT_WIDTH = 16
);
  logic                        start;
  logic                        arm;
  logic signed [BIT_WIDTH-1:0] yaw_rate;
  logic signed [BIT_WIDTH-1:0] roll_rate;
  logic signed [BIT_WIDTH-1:0] pitch_rate;
  logic signed [BIT_WIDTH-1:0] throttle_rate;
  logic        [BIT_WIDTH-1:0] motor_a_rate;
  logic        [BIT_WIDTH-1:0] motor_b_rate;
  logic        [BIT_WIDTH-1:0] motor_c_rate;
  logic        [BIT_WIDTH-1:0] motor_d_rate;
  logic                        motor_valid;
  logic                        busy;
  logic                        overrun;

  modport master (
    output start, arm, yaw_rate, roll_rate, pitch_rate, throttle_rate,
    input  motor_a_rate, motor_b_rate, motor_c_rate, motor_d_rate,
    input  motor_valid, busy, overrun
  );

  modport slave (
    input  start, arm, yaw_rate, roll_rate, pitch_rate, throttle_rate,
    output motor_a_rate, motor_b_rate, motor_c_rate, motor_d_rate,
    output motor_valid, busy, overrun
  );
endinterface

// File: rtl/motor_mixer_scheduler.sv
// Quad-motor mixer: one shared add/saturate datapath walks motors a..d one per
// clock, then publishes all four rates together with a one-cycle valid pulse.
module motor_mixer_scheduler #(
  parameter int unsigned                 BIT_WIDTH = 16,
  parameter logic signed [BIT_WIDTH-1:0] BIAS      = '0,
  parameter logic        [BIT_WIDTH-1:0] MOTOR_MAX = 16'h7FFF
) (
  input  logic           sys_clk,
  input  logic           rst_n,
  motor_mixer_if.slave   mix
);

  localparam int unsigned EXT_W = 3;
  localparam int unsigned SUM_W = BIT_WIDTH + EXT_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CALC    = 2'd1,
    PUBLISH = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic        [1:0]                idx_q;
  logic                             arm_q;
  logic signed [BIT_WIDTH-1:0]      yaw_q, roll_q, pitch_q, thr_q;
  logic        [3:0][BIT_WIDTH-1:0] shadow_q;
  logic        [3:0][BIT_WIDTH-1:0] motor_q;
  logic                             valid_q, busy_q, overrun_q;

  logic signed [BIT_WIDTH-1:0] yaw_h, roll_h, pitch_h;
  logic signed [SUM_W-1:0]     yaw_x, roll_x, pitch_x, thr_x, bias_x, max_x;
  logic signed [SUM_W-1:0]     sum_c;
  logic                        neg_y, neg_r, neg_p;
  logic        [BIT_WIDTH-1:0] shadow_c;

  // Halve the attitude terms (floor) and widen everything so the sum cannot wrap
  assign yaw_h   = yaw_q   >>> 1;
  assign roll_h  = roll_q  >>> 1;
  assign pitch_h = pitch_q >>> 1;
  assign yaw_x   = {{EXT_W{yaw_h[BIT_WIDTH-1]}},   yaw_h};
  assign roll_x  = {{EXT_W{roll_h[BIT_WIDTH-1]}},  roll_h};
  assign pitch_x = {{EXT_W{pitch_h[BIT_WIDTH-1]}}, pitch_h};
  assign thr_x   = {{EXT_W{thr_q[BIT_WIDTH-1]}},   thr_q};
  assign bias_x  = {{EXT_W{BIAS[BIT_WIDTH-1]}},    BIAS};
  assign max_x   = {{EXT_W{1'b0}},                 MOTOR_MAX};

  // Per-motor sign pattern: a(+,+,+) b(-,-,+) c(+,-,-) d(-,+,-)
  always_comb begin
    neg_y = 1'b0;
    neg_r = 1'b0;
    neg_p = 1'b0;
    case (idx_q)
      2'd0:    begin neg_y = 1'b0; neg_r = 1'b0; neg_p = 1'b0; end
      2'd1:    begin neg_y = 1'b1; neg_r = 1'b1; neg_p = 1'b0; end
      2'd2:    begin neg_y = 1'b0; neg_r = 1'b1; neg_p = 1'b1; end
      default: begin neg_y = 1'b1; neg_r = 1'b0; neg_p = 1'b1; end
    endcase
  end

  assign sum_c = bias_x + thr_x
               + (neg_y ? -yaw_x   : yaw_x)
               + (neg_r ? -roll_x  : roll_x)
               + (neg_p ? -pitch_x : pitch_x);

  // Clamp to [0, MOTOR_MAX]; a disarmed pass always yields zero
  always_comb begin
    shadow_c = sum_c[BIT_WIDTH-1:0];
    if (sum_c[SUM_W-1]) begin
      shadow_c = '0;
    end else if (sum_c > max_x) begin
      shadow_c = MOTOR_MAX;
    end
    if (!arm_q) begin
      shadow_c = '0;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mix.start) state_d = CALC;
      CALC:    if (idx_q == 2'd3) state_d = PUBLISH;
      PUBLISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Input capture, shadow fill, publish and status flags
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      arm_q     <= 1'b0;
      yaw_q     <= '0;
      roll_q    <= '0;
      pitch_q   <= '0;
      thr_q     <= '0;
      shadow_q  <= '0;
      motor_q   <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      overrun_q <= mix.start && (state_q != IDLE);
      case (state_q)
        IDLE: begin
          busy_q <= mix.start;
          idx_q  <= '0;
          if (mix.start) begin
            arm_q   <= mix.arm;
            yaw_q   <= mix.yaw_rate;
            roll_q  <= mix.roll_rate;
            pitch_q <= mix.pitch_rate;
            thr_q   <= mix.throttle_rate;
          end
        end
        CALC: begin
          busy_q          <= 1'b1;
          shadow_q[idx_q] <= shadow_c;
          idx_q           <= idx_q + 2'd1;
        end
        PUBLISH: begin
          busy_q  <= 1'b1;
          motor_q <= shadow_q;
          valid_q <= 1'b1;
        end
        default: begin
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign mix.motor_a_rate = motor_q[0];
  assign mix.motor_b_rate = motor_q[1];
  assign mix.motor_c_rate = motor_q[2];
  assign mix.motor_d_rate = motor_q[3];
  assign mix.motor_valid  = valid_q;
  assign mix.busy         = busy_q;
  assign mix.overrun      = overrun_q;

endmodule

// File: tb/tb_motor_mixer_scheduler.sv
// Randomized and directed checks of motor_mixer_scheduler against an arithmetic mixer model.
module tb_motor_mixer_scheduler;

  localparam int unsigned W   = 16;
  localparam int          MAX = 32767;
  localparam int          WIN = 14;

  localparam int SY [4] = '{ 1, -1,  1, -1};
  localparam int SR [4] = '{ 1, -1, -1,  1};
  localparam int SP [4] = '{ 1,  1, -1, -1};

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  motor_mixer_if #(.BIT_WIDTH(W)) mix_if ();

  motor_mixer_scheduler #(.BIT_WIDTH(W)) dut (
    .sys_clk (clk),
    .rst_n   (rst_n),
    .mix     (mix_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int half_floor(input int v);
    if (v >= 0) return v / 2;
    return -((-v + 1) / 2);
  endfunction

  function automatic logic [15:0] model_motor(input int m, input int y, input int r,
                                              input int p, input int t, input bit armed);
    int s;
    s = t + SY[m] * half_floor(y) + SR[m] * half_floor(r) + SP[m] * half_floor(p);
    if (!armed)   return 16'd0;
    if (s < 0)    return 16'd0;
    if (s > MAX)  return 16'(MAX);
    return 16'(s);
  endfunction

  function automatic logic [15:0] motor_out(input int m);
    case (m)
      0:       return mix_if.motor_a_rate;
      1:       return mix_if.motor_b_rate;
      2:       return mix_if.motor_c_rate;
      default: return mix_if.motor_d_rate;
    endcase
  endfunction

  // mode 0 plain pulse, 1 arm raised after capture, 2 overrun + input change, 3 start held
  task automatic run_pass(input string name, input logic signed [15:0] y, input logic signed [15:0] r,
                          input logic signed [15:0] p, input logic signed [15:0] t,
                          input bit armed, input int mode);
    logic [15:0]    exp_m [4];
    logic [WIN-1:0] v_bits, b_bits, o_bits;
    logic [WIN-1:0] v_exp, b_exp, o_exp;
    for (int m = 0; m < 4; m++) exp_m[m] = model_motor(m, int'(y), int'(r), int'(p), int'(t), armed);
    v_exp = (mode == 3) ? WIN'(14'h0820) : WIN'(14'h0020);
    b_exp = (mode == 3) ? WIN'(14'h0FFF) : WIN'(14'h003F);
    o_exp = (mode == 3) ? WIN'(14'h0FBE) : ((mode == 2) ? WIN'(14'h0004) : WIN'(14'h0000));
    v_bits = '0;
    b_bits = '0;
    o_bits = '0;
    mix_if.yaw_rate      = y;
    mix_if.roll_rate     = r;
    mix_if.pitch_rate    = p;
    mix_if.throttle_rate = t;
    mix_if.arm           = armed;
    mix_if.start         = 1'b1;
    for (int i = 0; i < WIN; i++) begin
      @(negedge clk);
      v_bits[i] = mix_if.motor_valid;
      b_bits[i] = mix_if.busy;
      o_bits[i] = mix_if.overrun;
      if (i == 5 || i == WIN - 1) begin
        for (int m = 0; m < 4; m++)
          check($sformatf("%s_m%0d_t%0d", name, m, i), 32'(motor_out(m)), 32'(exp_m[m]));
      end
      if (i == 0 && mode != 3) mix_if.start = 1'b0;
      if (i == 0 && mode == 2) begin
        mix_if.yaw_rate      = 16'($urandom);
        mix_if.roll_rate     = ~r;
        mix_if.pitch_rate    = 16'($urandom);
        mix_if.throttle_rate = t + 16'sd1234;
      end
      if (i == 1 && mode == 1) mix_if.arm = 1'b1;
      if (i == 1 && mode == 2) mix_if.start = 1'b1;
      if (i == 2 && mode == 2) mix_if.start = 1'b0;
      if (i == 11 && mode == 3) mix_if.start = 1'b0;
    end
    check({name, "_valid"},   32'(v_bits), 32'(v_exp));
    check({name, "_busy"},    32'(b_bits), 32'(b_exp));
    check({name, "_overrun"}, 32'(o_bits), 32'(o_exp));
  endtask

  task automatic reset_mid_pass();
    logic [9:0] act;
    mix_if.yaw_rate      = 16'sd200;
    mix_if.roll_rate     = 16'sd100;
    mix_if.pitch_rate    = 16'sd40;
    mix_if.throttle_rate = 16'sd1000;
    mix_if.arm           = 1'b1;
    mix_if.start         = 1'b1;
    @(negedge clk);
    mix_if.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_a",     32'(mix_if.motor_a_rate), 32'd0);
    check("rst_mid_d",     32'(mix_if.motor_d_rate), 32'd0);
    check("rst_mid_busy",  32'(mix_if.busy),         32'd0);
    check("rst_mid_valid", 32'(mix_if.motor_valid),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    act = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      act[i] = mix_if.motor_valid | mix_if.busy | (mix_if.motor_b_rate != 16'd0);
    end
    check("rst_mid_quiet", 32'(act), 32'd0);
  endtask

  initial begin
    logic signed [15:0] ry, rr, rp, rt;
    bit                 ra;
    int                 rm;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    mix_if.start         = 1'b0;
    mix_if.arm           = 1'b0;
    mix_if.yaw_rate      = '0;
    mix_if.roll_rate     = '0;
    mix_if.pitch_rate    = '0;
    mix_if.throttle_rate = '0;
    repeat (3) @(negedge clk);
    check("reset_a",       32'(mix_if.motor_a_rate), 32'd0);
    check("reset_c",       32'(mix_if.motor_c_rate), 32'd0);
    check("reset_valid",   32'(mix_if.motor_valid),  32'd0);
    check("reset_busy",    32'(mix_if.busy),         32'd0);
    check("reset_overrun", 32'(mix_if.overrun),      32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_pass("nominal",   16'sd200, 16'sd100, 16'sd40, 16'sd1000,  1'b1, 0);
    run_pass("sat_high",  16'sd2,   16'sd2,   16'sd2,  16'sd32767, 1'b1, 0);
    run_pass("sat_low",   -16'sd3,  16'sd0,   16'sd0,  16'sd0,     1'b1, 0);
    run_pass("disarmed",  16'sd200, 16'sd100, 16'sd40, 16'sd1000,  1'b0, 1);
    run_pass("overrun",   16'sd200, 16'sd100, 16'sd40, 16'sd1000,  1'b1, 2);
    run_pass("held",      -16'sd501, 16'sd77, -16'sd9, 16'sd5000,  1'b1, 3);
    reset_mid_pass();
    run_pass("post_rst",  16'sd200, 16'sd100, 16'sd40, 16'sd1000,  1'b1, 0);

    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 1) == 0) begin
        ry = 16'($signed($urandom_range(0, 8000)) - 4000);
        rr = 16'($signed($urandom_range(0, 8000)) - 4000);
        rp = 16'($signed($urandom_range(0, 8000)) - 4000);
        rt = 16'($urandom_range(0, 32767));
      end else begin
        ry = 16'($urandom);
        rr = 16'($urandom);
        rp = 16'($urandom);
        rt = 16'($urandom);
      end
      rm = int'($urandom_range(0, 3));
      ra = ($urandom_range(0, 3) != 0) && (rm != 1);
      run_pass($sformatf("rnd%0d", k), ry, rr, rp, rt, ra, rm);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
